// File: rtl/ecg_nn_pkg.sv
// Shared types and constants for the ECG fully connected front end.
package ecg_nn_pkg;

  localparam int unsigned DATA_W           = 8;
  localparam int unsigned WIN_LEN          = 15;
  localparam int unsigned NODE_LAT_DEFAULT = 3;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Index 0 is the oldest sample, WIN_LEN-1 the newest.
  typedef logic [WIN_LEN-1:0][DATA_W-1:0] taps_t;

endpackage

// File: rtl/ecg_window_buffer_if.sv
// Sample stream in, window taps and timing pulses out.
interface ecg_window_buffer_if;
  import ecg_nn_pkg::*;

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              flush;
  logic [DATA_W-1:0] A0x,  A1x,  A2x,  A3x,  A4x;
  logic [DATA_W-1:0] A5x,  A6x,  A7x,  A8x,  A9x;
  logic [DATA_W-1:0] A10x, A11x, A12x, A13x, A14x;
  logic              win_valid;
  logic              nout_valid;
  logic [15:0]       win_idx;

  modport master (
    output sample_in, sample_valid, flush,
    input  A0x, A1x, A2x, A3x, A4x, A5x, A6x, A7x, A8x, A9x,
    input  A10x, A11x, A12x, A13x, A14x,
    input  win_valid, nout_valid, win_idx
  );

  modport slave (
    input  sample_in, sample_valid, flush,
    output A0x, A1x, A2x, A3x, A4x, A5x, A6x, A7x, A8x, A9x,
    output A10x, A11x, A12x, A13x, A14x,
    output win_valid, nout_valid, win_idx
  );

endinterface

// File: rtl/valid_delay.sv
// Fixed-depth pulse delay line; holds any pattern of pulses, including back-to-back.
module valid_delay #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_pulse,
  output logic o_pulse
);

  logic [DEPTH-1:0] r_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line <= '0;
    end else if (i_clear) begin
      r_line <= '0;
    end else begin
      r_line[0] <= i_pulse;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_line[k] <= r_line[k-1];
      end
    end
  end

  assign o_pulse = r_line[DEPTH-1];

endmodule

// File: rtl/ecg_window_buffer.sv
// 15-tap sliding window over the ECG sample stream with window and node-output strobes.
module ecg_window_buffer
  import ecg_nn_pkg::*;
#(
  parameter int unsigned STRIDE   = 1,
  parameter int unsigned NODE_LAT = NODE_LAT_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  ecg_window_buffer_if.slave bus
);

  localparam logic [7:0] STRIDE_LAST = 8'(STRIDE - 1);
  localparam logic [3:0] FILL_LAST   = 4'(WIN_LEN - 1);

  state_t      r_state;
  state_t      w_next_state;
  taps_t       r_taps;
  logic [3:0]  r_fill;
  logic [7:0]  r_stride;
  logic        r_win_valid;
  logic [15:0] r_win_idx;
  logic        w_accept;
  logic        w_emit;

  assign w_accept = bus.sample_valid & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.flush) begin
      w_next_state = FILL;
    end else if (w_accept && r_state == FILL && r_fill == FILL_LAST) begin
      w_next_state = RUN;
    end
  end

  // Window completion is decided on the accepting edge, so the strobe lines up with the taps.
  always_comb begin
    w_emit = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        FILL: w_emit = (r_fill == FILL_LAST);
        RUN:  w_emit = (r_stride == STRIDE_LAST);
        default: w_emit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taps      <= '0;
      r_fill      <= '0;
      r_stride    <= '0;
      r_win_valid <= 1'b0;
      r_win_idx   <= '0;
    end else if (bus.flush) begin
      r_taps      <= '0;
      r_fill      <= '0;
      r_stride    <= '0;
      r_win_valid <= 1'b0;
      r_win_idx   <= '0;
    end else begin
      r_win_valid <= w_emit;
      if (r_win_valid) begin
        r_win_idx <= r_win_idx + 16'd1;
      end
      if (w_accept) begin
        r_taps[WIN_LEN-2:0]  <= r_taps[WIN_LEN-1:1];
        r_taps[WIN_LEN-1]    <= bus.sample_in;
        if (r_state == FILL) begin
          r_fill   <= r_fill + 4'd1;
          r_stride <= '0;
        end else if (r_stride == STRIDE_LAST) begin
          r_stride <= '0;
        end else begin
          r_stride <= r_stride + 8'd1;
        end
      end
    end
  end

  valid_delay #(
    .DEPTH (NODE_LAT)
  ) u_nout_delay (
    .clk     (clk),
    .rst     (reset),
    .i_clear (bus.flush),
    .i_pulse (r_win_valid),
    .o_pulse (bus.nout_valid)
  );

  assign bus.win_valid = r_win_valid;
  assign bus.win_idx   = r_win_idx;
  assign bus.A0x       = r_taps[0];
  assign bus.A1x       = r_taps[1];
  assign bus.A2x       = r_taps[2];
  assign bus.A3x       = r_taps[3];
  assign bus.A4x       = r_taps[4];
  assign bus.A5x       = r_taps[5];
  assign bus.A6x       = r_taps[6];
  assign bus.A7x       = r_taps[7];
  assign bus.A8x       = r_taps[8];
  assign bus.A9x       = r_taps[9];
  assign bus.A10x      = r_taps[10];
  assign bus.A11x      = r_taps[11];
  assign bus.A12x      = r_taps[12];
  assign bus.A13x      = r_taps[13];
  assign bus.A14x      = r_taps[14];

endmodule

// File: tb/tb_ecg_window_buffer.sv
// Bench for ecg_window_buffer at STRIDE=1 and STRIDE=4 against a sample-count reference model.
module tb_ecg_window_buffer;
  import ecg_nn_pkg::*;

  localparam int LAT = NODE_LAT_DEFAULT;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] d_data  = '0;
  logic       d_valid = 1'b0;
  logic       d_flush = 1'b0;

  ecg_window_buffer_if bus1 ();
  ecg_window_buffer_if bus4 ();

  assign bus1.sample_in    = d_data;
  assign bus1.sample_valid = d_valid;
  assign bus1.flush        = d_flush;
  assign bus4.sample_in    = d_data;
  assign bus4.sample_valid = d_valid;
  assign bus4.flush        = d_flush;

  ecg_window_buffer #(.STRIDE(1), .NODE_LAT(LAT)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  ecg_window_buffer #(.STRIDE(4), .NODE_LAT(LAT)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  // Reference: last 15 accepted samples, accepted count since restart, windows per stride.
  int          strides [2] = '{1, 4};
  logic [7:0]  m_taps [WIN_LEN];
  int          m_n;
  logic        m_win [2];
  logic [15:0] m_idx [2];
  logic        m_wv [2][4];
  logic        m_fl [4];
  int          m_e;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic model_reset();
    for (int k = 0; k < WIN_LEN; k++) m_taps[k] = '0;
    m_n = 0;
    m_e = 0;
    for (int s = 0; s < 2; s++) begin
      m_win[s] = 1'b0;
      m_idx[s] = '0;
      for (int j = 0; j < 4; j++) m_wv[s][j] = 1'b0;
    end
    for (int j = 0; j < 4; j++) m_fl[j] = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic f, input logic [7:0] d);
    m_e++;
    if (f) begin
      for (int k = 0; k < WIN_LEN; k++) m_taps[k] = '0;
      m_n = 0;
      for (int s = 0; s < 2; s++) begin
        m_idx[s] = '0;
        m_win[s] = 1'b0;
      end
    end else begin
      for (int s = 0; s < 2; s++) m_idx[s] = m_idx[s] + {15'd0, m_win[s]};
      if (v) begin
        for (int k = 0; k < WIN_LEN - 1; k++) m_taps[k] = m_taps[k+1];
        m_taps[WIN_LEN-1] = d;
        m_n++;
      end
      for (int s = 0; s < 2; s++)
        m_win[s] = v && (m_n >= WIN_LEN) && (((m_n - WIN_LEN) % strides[s]) == 0);
    end
    for (int s = 0; s < 2; s++) m_wv[s][m_e % 4] = m_win[s];
    m_fl[m_e % 4] = f;
  endtask

  function automatic logic exp_nout(input int s);
    logic r;
    if (m_e < LAT) return 1'b0;
    r = m_wv[s][(m_e - LAT) % 4];
    for (int j = 0; j < LAT; j++) if (m_fl[(m_e - j) % 4]) r = 1'b0;
    return r;
  endfunction

  function automatic logic [8*WIN_LEN-1:0] exp_taps();
    logic [8*WIN_LEN-1:0] v;
    for (int k = 0; k < WIN_LEN; k++) v[8*k +: 8] = m_taps[k];
    return v;
  endfunction

  function automatic logic [8*WIN_LEN-1:0] taps_of(input int s);
    if (s == 0)
      return {bus1.A14x, bus1.A13x, bus1.A12x, bus1.A11x, bus1.A10x, bus1.A9x, bus1.A8x, bus1.A7x,
              bus1.A6x, bus1.A5x, bus1.A4x, bus1.A3x, bus1.A2x, bus1.A1x, bus1.A0x};
    return {bus4.A14x, bus4.A13x, bus4.A12x, bus4.A11x, bus4.A10x, bus4.A9x, bus4.A8x, bus4.A7x,
            bus4.A6x, bus4.A5x, bus4.A4x, bus4.A3x, bus4.A2x, bus4.A1x, bus4.A0x};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s.S%0d.taps", ctx, strides[s]), 128'(taps_of(s)), 128'(exp_taps()));
      chk($sformatf("%s.S%0d.win_valid", ctx, strides[s]),
          128'(s == 0 ? bus1.win_valid : bus4.win_valid), 128'(m_win[s]));
      chk($sformatf("%s.S%0d.nout_valid", ctx, strides[s]),
          128'(s == 0 ? bus1.nout_valid : bus4.nout_valid), 128'(exp_nout(s)));
      chk($sformatf("%s.S%0d.win_idx", ctx, strides[s]),
          128'(s == 0 ? bus1.win_idx : bus4.win_idx), 128'(m_idx[s]));
    end
  endtask

  task automatic step(input string ctx, input logic v, input logic f, input logic [7:0] d);
    d_valid = v;
    d_flush = f;
    d_data  = d;
    @(posedge clk);
    model_edge(v, f, d);
    #1;
    check_all(ctx);
  endtask

  initial begin
    int acc;
    model_reset();
    #1;
    check_all("reset");
    #10;
    reset = 1'b0;

    for (int i = 1; i <= 23; i++) begin
      step("ramp", 1'b1, 1'b0, 8'(i));
      if (i == 15) begin
        chk("first_win.A0x", 128'(bus1.A0x), 128'd1);
        chk("first_win.A14x", 128'(bus1.A14x), 128'd15);
        chk("first_win.idx", 128'(bus1.win_idx), 128'd0);
      end
    end
    chk("stride4_last.A14x", 128'(bus4.A14x), 128'd23);

    step("min_neg", 1'b1, 1'b0, 8'h80);
    chk("min_neg.A14x", 128'(bus1.A14x), 128'h80);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b0, 8'($urandom));

    step("flush_a", 1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 45; i++) begin
      step("sparse", 1'b1, 1'b0, 8'($urandom));
      step("sparse_idle", 1'b0, 1'b0, 8'($urandom));
      step("sparse_idle", 1'b0, 1'b0, 8'($urandom));
    end

    step("flush_b", 1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 20; i++) step("pre_flush", 1'b1, 1'b0, 8'($urandom));
    step("flush_pending", 1'b1, 1'b1, 8'($urandom));
    chk("flush_pending.A14x", 128'(bus1.A14x), 128'd0);
    for (int i = 0; i < 4; i++) step("post_flush", 1'b0, 1'b0, 8'($urandom));

    acc = 0;
    while (acc < 30) begin
      logic v;
      v = ($urandom_range(0, 9) < 7);
      if (v) acc++;
      step("refill", v, 1'b0, 8'($urandom));
    end

    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #3;
    reset = 1'b0;
    for (int i = 0; i < 18; i++) step("after_rst", 1'b1, 1'b0, 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
